btb_assoc: RTL and testbench
============================

// Module: btb_assoc
// PURPOSE
//  Parametrised set-associative branch target buffer with per-entry 2-bit saturating direction
//  counters. Sits in the fetch stage: combinational lookup on the fetch PC returns hit, predicted
//  direction and target. Resolved branches from execute train it through a one-cycle write port.
//  Adds ways, replacement, direction prediction, flush and reset over the direct-mapped BTB.
// PARAMETERS
//  PC_W   17  PC width in bits (word-aligned; pc[1:0] ignored)
//  SETS   16  number of sets, power of 2, >=2; IDX_W = log2(SETS)
//  WAYS   2   ways per set, power of 2, >=1; WAY_W = max(1,log2(WAYS))
//  TAG_W  derived = PC_W-IDX_W-2; index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2]
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  pc           in   PC_W   fetch PC to look up
//  btb_hit      out  1      valid entry with matching tag in pc's set
//  pred_taken   out  1      hit & counter MSB of matching entry
//  pred_pc      out  PC_W   target of matching entry; 0 on miss
//  upd_valid    in   1      train with a resolved branch this cycle
//  upd_pc       in   PC_W   PC of the resolved branch
//  upd_taken    in   1      resolved direction
//  upd_target   in   PC_W   resolved target (used when taken)
//  flush        in   1      invalidate every entry
// BEHAVIOUR
//  - Interface fixed: one clock clk; reset rst is synchronous and active-high.
//  - Entry = {valid, tag[TAG_W], target[PC_W], ctr[2]}. Per set: round-robin victim pointer rr[WAY_W].
//  - Reset: all valid=0, tag/target/ctr=0, rr=0. Outputs derive combinationally from state, so after
//    reset: btb_hit=0, pred_taken=0, pred_pc=0.
//  - Lookup: combinational, zero latency. At most one way matches (guaranteed by update rules).
//    On miss, pred_taken=0 and pred_pc=0.
//  - Update (upd_valid=1, takes effect at the next rising edge):
//    * Hit in way w: ctr saturating +1 if taken, else -1 (range 0..3). target<=upd_target only if
//      taken. rr unchanged.
//    * Miss, taken: allocate the lowest-index invalid way if any (rr unchanged). Otherwise evict
//      way rr and advance rr (wraps WAYS-1 -> 0). New entry gets valid=1, tag, target, ctr=2'b10.
//    * Miss, not taken: no change.
//  - Read-during-write: a lookup in the same cycle as an update to the same set sees the pre-update
//    contents. The new value is visible the following cycle.
//  - flush=1: all valid<=0 at the next edge; rr and data are retained. flush beats a simultaneous
//    update (the update is dropped).
//  - rst beats flush and update. Reset mid-training drops the in-flight update.
//  - WAYS=1: degenerates to direct-mapped; rr is held at 0.
// TESTING  (PC_W=17, SETS=16, WAYS=2; index=pc[5:2])
//  1 reset, lookup pc=0x00040 -> btb_hit=0, pred_taken=0, pred_pc=0
//  2 upd pc=0x00040 taken tgt=0x00100; next cycle lookup 0x00040 -> hit=1, taken=1, pred_pc=0x00100
//  3 then 3x upd 0x00040 not-taken -> ctr 01,00,00 (saturated); hit=1, taken=0, pred_pc=0x00100;
//    then 1x taken -> ctr 01, taken=0
//  4 fresh reset; allocate taken 0x00040, 0x00080, 0x000C0 (all set 0) -> ways 0,1, then evict way0
//    with rr 0->1; 0x00040 misses, 0x00080/0x000C0 hit; a 4th alloc 0x00100 evicts way1
//  5 same-cycle lookup+upd to 0x00040 on an empty BTB -> hit=0 that cycle, hit=1 the next
//  6 flush with simultaneous taken upd 0x00200 -> every address misses next cycle, incl. 0x00200;
//    rst asserted with upd_valid=1 -> all miss

Source files
------------

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : btb_assoc
// Purpose  : Set-associative branch target buffer with 2-bit direction counters,
//            round-robin replacement, flush, and a one-cycle training port.
// Revision : 1.0
// ============================================================================
module btb_assoc #(
  parameter int PC_W = 17,
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc,
  output logic            btb_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [WAY_W-1:0] C_LAST_WAY = WAY_W'(WAYS - 1);

  logic             r_valid  [SETS][WAYS];
  logic [TAG_W-1:0] r_tag    [SETS][WAYS];
  logic [PC_W-1:0]  r_target [SETS][WAYS];
  logic [1:0]       r_ctr    [SETS][WAYS];
  logic [WAY_W-1:0] r_rr     [SETS];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_up_hit, w_has_free;
  logic [WAY_W-1:0] w_up_way, w_free_way, w_alloc_way, w_rr_next;
  logic             w_unused;

  assign w_lk_idx = pc[IDX_W+1:2];
  assign w_lk_tag = pc[PC_W-1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[PC_W-1:IDX_W+2];
  assign w_unused = ^{pc[1:0], upd_pc[1:0]};

  // Lookup: at most one way can match, so a simple priority scan suffices.
  always_comb begin
    btb_hit    = 1'b0;
    pred_taken = 1'b0;
    pred_pc    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
        btb_hit    = 1'b1;
        pred_taken = r_ctr[w_lk_idx][w][1];
        pred_pc    = r_target[w_lk_idx][w];
      end
    end
  end

  // Training-side match and allocation choice; the downward scan leaves the lowest free way.
  always_comb begin
    w_up_hit   = 1'b0;
    w_up_way   = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = WAY_W'(w);
      end
      if (!r_valid[w_up_idx][w]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  assign w_alloc_way = w_has_free ? w_free_way : r_rr[w_up_idx];

  generate
    if (WAYS == 1) begin : g_rr_direct
      assign w_rr_next = '0;
    end else begin : g_rr_assoc
      assign w_rr_next = (r_rr[w_up_idx] == C_LAST_WAY) ? '0 : r_rr[w_up_idx] + 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w]  <= 1'b0;
          r_tag[s][w]    <= '0;
          r_target[s][w] <= '0;
          r_ctr[s][w]    <= 2'b00;
        end
      end
    end else if (flush) begin
      // Only valid bits clear; data and replacement pointers are retained.
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
        end
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          r_target[w_up_idx][w_up_way] <= upd_target;
          if (r_ctr[w_up_idx][w_up_way] != 2'b11)
            r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] + 2'b01;
        end else if (r_ctr[w_up_idx][w_up_way] != 2'b00) begin
          r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] - 2'b01;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx][w_alloc_way]  <= 1'b1;
        r_tag[w_up_idx][w_alloc_way]    <= w_up_tag;
        r_target[w_up_idx][w_alloc_way] <= upd_target;
        r_ctr[w_up_idx][w_alloc_way]    <= 2'b10;
        if (!w_has_free)
          r_rr[w_up_idx] <= w_rr_next;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_assoc
// Purpose  : Scoreboard bench for btb_assoc: stimulus pushes expected lookups,
//            a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
module tb_btb_assoc;
  logic        clk;
  logic        rst;
  logic [16:0] pc;
  logic        btb_hit;
  logic        pred_taken;
  logic [16:0] pred_pc;
  logic        upd_valid;
  logic [16:0] upd_pc;
  logic        upd_taken;
  logic [16:0] upd_target;
  logic        flush;

  logic        chk_en;
  logic        done;
  int          checks;
  int          errors;

  typedef struct {
    string       name;
    logic        hit;
    logic        tk;
    logic [16:0] tgt;
  } exp_t;
  exp_t sb_q[$];

  btb_assoc #(.PC_W(17), .SETS(16), .WAYS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .btb_hit    (btb_hit),
    .pred_taken (pred_taken),
    .pred_pc    (pred_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; when c is set the lookup result for this cycle is expected.
  task automatic step(input string nm, input logic c, input logic [16:0] lpc,
                      input logic uv, input logic [16:0] upc, input logic ut,
                      input logic [16:0] utg, input logic fl, input logic rs,
                      input logic eh, input logic et, input logic [16:0] ep);
    exp_t e;
    pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    flush = fl; rst = rs; chk_en = c;
    if (c) begin
      e.name = nm; e.hit = eh; e.tk = et; e.tgt = ep;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string nm, input logic [16:0] lpc,
                      input logic eh, input logic et, input logic [16:0] ep);
    step(nm, 1'b1, lpc, 1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 1'b0, eh, et, ep);
  endtask

  task automatic upd(input logic [16:0] upc, input logic ut, input logic [16:0] utg);
    step("", 1'b0, 17'h0, 1'b1, upc, ut, utg, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
  endtask

  task automatic do_reset();
    step("", 1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0);
  endtask

  // Monitor: the only process that touches the counters.
  initial begin
    exp_t e;
    int   cyc;
    checks = 0; errors = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: output presented with no expectation queued");
        end else begin
          e = sb_q.pop_front();
          if (btb_hit !== e.hit || pred_taken !== e.tk || pred_pc !== e.tgt) begin
            errors++;
            $display("FAIL %s: got hit=%b taken=%b pc=%h, want hit=%b taken=%b pc=%h",
                     e.name, btb_hit, pred_taken, pred_pc, e.hit, e.tk, e.tgt);
          end
        end
      end
      if (done || cyc > 2000) begin
        if (!done) begin
          errors++;
          $display("FAIL timeout: stimulus did not finish within %0d cycles", cyc);
        end
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expectations never checked, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    done = 1'b0; chk_en = 1'b0; rst = 1'b1; flush = 1'b0; pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state, then allocation (same-cycle lookup sees the old, empty contents)
    look("reset_lookup", 17'h00040, 1'b0, 1'b0, 17'h0);
    step("alloc_same_cycle", 1'b1, 17'h00040, 1'b1, 17'h00040, 1'b1, 17'h00100,
         1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    look("alloc_hit", 17'h00040, 1'b1, 1'b1, 17'h00100);

    // Counter decrements 10 -> 01 -> 00 -> 00, each lookup sees the pre-update value
    step("nt1_pre", 1'b1, 17'h00040, 1'b1, 17'h00040, 1'b0, 17'h0, 1'b0, 1'b0, 1'b1, 1'b1, 17'h00100);
    step("nt2_pre", 1'b1, 17'h00040, 1'b1, 17'h00040, 1'b0, 17'h0, 1'b0, 1'b0, 1'b1, 1'b0, 17'h00100);
    step("nt3_pre", 1'b1, 17'h00040, 1'b1, 17'h00040, 1'b0, 17'h0, 1'b0, 1'b0, 1'b1, 1'b0, 17'h00100);
    look("ctr_sat_low", 17'h00040, 1'b1, 1'b0, 17'h00100);
    upd(17'h00040, 1'b1, 17'h00100);
    look("ctr_01_not_taken", 17'h00040, 1'b1, 1'b0, 17'h00100);
    upd(17'h00040, 1'b1, 17'h00100);
    look("ctr_10_taken", 17'h00040, 1'b1, 1'b1, 17'h00100);
    upd(17'h00044, 1'b0, 17'h00700);
    look("miss_nt_no_alloc", 17'h00044, 1'b0, 1'b0, 17'h0);

    // Replacement in set 0
    do_reset();
    upd(17'h00040, 1'b1, 17'h01000);
    upd(17'h00080, 1'b1, 17'h02000);
    look("way1_fill_0x40", 17'h00040, 1'b1, 1'b1, 17'h01000);
    upd(17'h000C0, 1'b1, 17'h03000);
    look("evict_way0", 17'h00040, 1'b0, 1'b0, 17'h0);
    look("keep_0x80", 17'h00080, 1'b1, 1'b1, 17'h02000);
    look("new_0xC0", 17'h000C0, 1'b1, 1'b1, 17'h03000);
    upd(17'h00100, 1'b1, 17'h04000);
    look("evict_way1", 17'h00080, 1'b0, 1'b0, 17'h0);
    look("keep_0xC0", 17'h000C0, 1'b1, 1'b1, 17'h03000);
    look("new_0x100", 17'h00100, 1'b1, 1'b1, 17'h04000);
    upd(17'h000C0, 1'b1, 17'h05000);
    look("hit_target_update", 17'h000C0, 1'b1, 1'b1, 17'h05000);

    // Fresh reset: same-cycle lookup and update
    do_reset();
    step("rdw_old", 1'b1, 17'h00040, 1'b1, 17'h00040, 1'b1, 17'h00100,
         1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    look("rdw_new", 17'h00040, 1'b1, 1'b1, 17'h00100);

    // Flush beats a simultaneous update
    step("flush_pre", 1'b1, 17'h00040, 1'b1, 17'h00200, 1'b1, 17'h00300,
         1'b1, 1'b0, 1'b1, 1'b1, 17'h00100);
    look("flush_0x40", 17'h00040, 1'b0, 1'b0, 17'h0);
    look("flush_drop_upd", 17'h00200, 1'b0, 1'b0, 17'h0);

    // Reset beats an in-flight update
    upd(17'h00040, 1'b1, 17'h00600);
    look("realloc", 17'h00040, 1'b1, 1'b1, 17'h00600);
    step("", 1'b0, 17'h0, 1'b1, 17'h00080, 1'b1, 17'h00800, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0);
    look("rst_clears", 17'h00040, 1'b0, 1'b0, 17'h0);
    look("rst_drop_upd", 17'h00080, 1'b0, 1'b0, 17'h0);

    chk_en = 1'b0;
    done   = 1'b1;
  end
endmodule
`default_nettype wire
